// File: rtl/fifo_pkg.sv
// Shared types and helpers for the burst-drain block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// drain_state_t : drain FSM encoding (IDLE / BURST / LAST).
// len_width()   : bit width needed to hold a burst length of 0..max_len.
package fifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      LAST  = 2'd2   // final word registered, waiting for its handshake
   } drain_state_t;

   function automatic int len_width(input int max_len);
      return (max_len < 1) ? 1 : $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/drain_out_reg.sv
// Output stage of the burst drain: one data/sop/eop register with valid/ready hold.
// Latency: 1 cycle from i_load to o_valid.
// Backpressure: word held stable while o_valid=1 and i_ready=0; loads only when told to.
//
// Ports: clk/rstb (async active-low) / sclr (sync clear, drops any held word),
//        i_load + i_data/i_sop/i_eop (capture strobe and payload), i_ready (downstream accept),
//        o_data/o_valid/o_sop/o_eop (registered stream outputs).
module drain_out_reg #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  sclr,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_sop,
   input  logic                  i_eop,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_sop,
   output logic                  o_eop
);

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_sop;
   logic                  r_eop;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
      end else if (sclr) begin
         r_valid <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
      end else if (i_load) begin
         // The caller only loads when the register is empty or being drained.
         r_data  <= i_data;
         r_valid <= 1'b1;
         r_sop   <= i_sop;
         r_eop   <= i_eop;
      end else if (i_ready) begin
         r_valid <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_sop   = r_sop;
   assign o_eop   = r_eop;

endmodule

// File: rtl/fifo_burst_drain.sv
// Drains a look-ahead sync FIFO as framed bursts (full bursts, or timed-out partial ones).
// Latency: popped word appears on m_data one cycle after fifo_rd_en; 1 word/cycle sustained.
// Backpressure: m_ready=0 holds the output word and stops popping; empty FIFO inserts bubbles.
//
// Ports: clk, rstb (async active-low), sclr (sync clear);
//        fifo_data/fifo_empty/fifo_uw in from the FIFO, fifo_rd_en out to it;
//        m_data/m_valid/m_ready/m_sop/m_eop/m_len output stream; busy = FSM not IDLE.
module fifo_burst_drain
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int BURST_LEN  = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                             clk,
   input  logic                             rstb,
   input  logic                             sclr,
   input  logic [DATA_WIDTH-1:0]            fifo_data,
   input  logic                             fifo_empty,
   input  logic [ADDR_WIDTH:0]              fifo_uw,
   output logic                             fifo_rd_en,
   output logic [DATA_WIDTH-1:0]            m_data,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic                             m_sop,
   output logic                             m_eop,
   output logic [len_width(BURST_LEN)-1:0]  m_len,
   output logic                             busy
);

   localparam int LW  = len_width(BURST_LEN);
   localparam int UWW = ADDR_WIDTH + 1;
   localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [UWW-1:0] UW_BL  = UWW'(BURST_LEN);
   localparam logic [LW-1:0]  LEN_BL = LW'(BURST_LEN);
   localparam logic [TW-1:0]  TO_MAX = TW'(TIMEOUT);

   drain_state_t   r_state;
   logic [LW-1:0]  r_len;
   logic [LW-1:0]  r_rem;
   logic [TW-1:0]  r_timer;

   logic w_full;
   logic w_partial;
   logic w_tmo;
   logic w_hs;
   logic w_chain;
   logic w_load_b;
   logic w_load;
   logic w_sop;
   logic w_eop;

   assign w_full    = (fifo_uw >= UW_BL);
   assign w_partial = (fifo_uw != '0) && (fifo_uw < UW_BL);
   assign w_tmo     = (TIMEOUT != 0) && (r_timer == TO_MAX) && (fifo_uw != '0);
   assign w_hs      = m_valid & m_ready;

   // Back-to-back full bursts: the eop handshake in LAST also loads the next
   // burst's first word, so the output register never goes empty in between.
   assign w_chain   = (r_state == LAST) && w_hs && w_full && !fifo_empty;
   assign w_load_b  = (r_state == BURST) && (r_rem != '0) && !fifo_empty &&
                      (!m_valid || m_ready);
   assign w_load    = !sclr && (w_load_b || w_chain);

   // First word of a burst is the one loaded while remaining still equals len.
   assign w_sop     = w_chain || (r_rem == r_len);
   assign w_eop     = w_chain ? (BURST_LEN == 1) : (r_rem == LW'(1));

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state <= IDLE;
         r_len   <= '0;
         r_rem   <= '0;
         r_timer <= '0;
      end else if (sclr) begin
         r_state <= IDLE;
         r_rem   <= '0;
         r_timer <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_full) begin
                  r_state <= BURST;
                  r_len   <= LEN_BL;
                  r_rem   <= LEN_BL;
                  r_timer <= '0;
               end else if (w_tmo) begin
                  // fifo_uw < BURST_LEN here, so it fits the length width.
                  r_state <= BURST;
                  r_len   <= LW'(fifo_uw);
                  r_rem   <= LW'(fifo_uw);
                  r_timer <= '0;
               end else if (fifo_empty) begin
                  r_timer <= '0;
               end else if (w_partial && (r_timer != TO_MAX)) begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            BURST: begin
               if (w_load) begin
                  r_rem <= r_rem - LW'(1);
                  if (r_rem == LW'(1)) begin
                     r_state <= LAST;
                  end
               end
            end
            LAST: begin
               if (w_chain) begin
                  // The chained load already consumed the first word.
                  r_len   <= LEN_BL;
                  r_rem   <= LEN_BL - LW'(1);
                  r_state <= (BURST_LEN == 1) ? LAST : BURST;
               end else if (w_hs) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   drain_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_reg (
      .clk     (clk),
      .rstb    (rstb),
      .sclr    (sclr),
      .i_load  (w_load),
      .i_data  (fifo_data),
      .i_sop   (w_sop),
      .i_eop   (w_eop),
      .i_ready (m_ready),
      .o_data  (m_data),
      .o_valid (m_valid),
      .o_sop   (m_sop),
      .o_eop   (m_eop)
   );

   assign fifo_rd_en = w_load;
   assign m_len      = r_len;
   assign busy       = (r_state != IDLE);

endmodule

// File: doc/fifo_burst_drain.md
FIFO_BURST_DRAIN -- requirements
Module: fifo_burst_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of FIFO data and output stream data.
REQ-002 Parameter ADDR_WIDTH, default 8: address width of the upstream FIFO; its used-word input is ADDR_WIDTH+1 bits.
REQ-003 Parameter BURST_LEN, default 16: maximum words per burst; range 1..2**ADDR_WIDTH.
REQ-004 Parameter TIMEOUT, default 255: idle cycles before a partial burst is flushed; 0 disables partial bursts.
REQ-005 Port clk, input, 1: clock; all logic is rising-edge.
REQ-006 Port rstb, input, 1: reset, asynchronous, active-low.
REQ-007 Port sclr, input, 1: synchronous clear, active-high.
REQ-008 Port fifo_data, input, DATA_WIDTH: look-ahead FIFO head word, valid whenever fifo_empty=0.
REQ-009 Port fifo_empty, input, 1: FIFO empty flag.
REQ-010 Port fifo_uw, input, ADDR_WIDTH+1: FIFO used-word count.
REQ-011 Port fifo_rd_en, output, 1: pop strobe to FIFO.
REQ-012 Port m_data, output, DATA_WIDTH: output stream data.
REQ-013 Port m_valid, output, 1: output word valid.
REQ-014 Port m_ready, input, 1: downstream accept.
REQ-015 Port m_sop, output, 1: first word of burst, qualified by m_valid.
REQ-016 Port m_eop, output, 1: last word of burst, qualified by m_valid.
REQ-017 Port m_len, output, clog2(BURST_LEN+1): length of the current burst, stable from m_sop through the m_eop handshake.
REQ-018 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-019 FSM states: IDLE, BURST, LAST (the final word is registered but not yet accepted).
REQ-020 IDLE->BURST when fifo_uw >= BURST_LEN; latch len=BURST_LEN.
REQ-021 IDLE->BURST when the timer equals TIMEOUT, TIMEOUT != 0 and fifo_uw != 0; latch len=fifo_uw.
REQ-022 Timer runs in IDLE only.
  - Increments while fifo_uw is in 1..BURST_LEN-1.
  - Clears when fifo_empty=1 and on every IDLE->BURST transition.
  - Saturates at TIMEOUT.
REQ-023 Output register loads when: state=BURST, remaining>0, fifo_empty=0, and (m_valid=0 or m_ready=1).
REQ-024 fifo_rd_en is asserted in exactly the cycles the output register loads, capturing fifo_data.
REQ-025 Latency: a popped word appears on m_data with m_valid=1 on the next cycle.
REQ-026 Throughput is one word per cycle while m_ready stays high.
REQ-027 m_data, m_sop and m_eop hold stable while m_valid=1 and m_ready=0.
REQ-028 The first loaded word of a burst carries m_sop=1; word number len carries m_eop=1; a len=1 burst asserts both on the same word.
REQ-029 The remaining counter loads len on burst start and decrements on each load; when the load of the eop word occurs, state becomes LAST.
REQ-030 LAST->IDLE on m_valid & m_ready.
REQ-031 LAST->BURST directly on the same eop handshake if the REQ-020 condition holds, giving zero bubble between back-to-back full bursts.
REQ-032 fifo_empty=1 mid-burst stalls the pop and inserts m_valid=0 bubbles; it never aborts the burst.
REQ-033 sclr forces IDLE, m_valid=0, timer=0 and remaining=0 next cycle, discarding any held word; fifo_rd_en=0 in the sclr cycle.
REQ-034 Arithmetic: the fifo_uw comparison is unsigned at ADDR_WIDTH+1 bits; a counter wraps never occur (all counters saturate or are bounded by len).

Reset
REQ-035 On rstb low: state=IDLE; m_valid, m_sop, m_eop, fifo_rd_en, busy = 0; m_data=0; m_len=0; timer=0; remaining=0.
REQ-036 Reset assertion mid-burst takes effect immediately, regardless of clk.
REQ-037 After reset deassertion, the first burst decision is made on the first clock edge.

Structure
REQ-038 A shared package fifo_pkg shall hold the FSM state enum (drain_state_t) and a clog2-based helper for the m_len width.
REQ-039 One sub-module, drain_out_reg, shall hold the output data/sop/eop register with the valid/ready hold logic; the FSM and counters stay in the top.
REQ-040 fifo_burst_drain shall connect directly to a look-ahead sync FIFO: fifo_data, fifo_empty and fifo_uw from the FIFO; fifo_rd_en to the FIFO rd_en.

Verification
REQ-041 Full burst: BURST_LEN=4, preload 4 words A..D, m_ready=1 -> A..D on consecutive cycles; sop on A, eop on D, m_len=4, fifo_rd_en high 4 cycles.
REQ-042 Timeout flush: TIMEOUT=8, write 3 words then stop -> burst starts 8 idle cycles later; m_len=3, eop on word 3.
REQ-043 Backpressure: m_ready toggles 1,0,0,1 during a burst -> m_data held while m_ready=0; no word lost or duplicated; pops match accepts.
REQ-044 Back-to-back: 8 words present, BURST_LEN=4 -> two bursts; second sop on the cycle after first eop handshake; no bubble.
REQ-045 sclr mid-burst after 2 of 4 words -> next cycle m_valid=0, busy=0; fifo_rd_en never asserted in the sclr cycle.
REQ-046 Reset mid-burst: rstb low asynchronously -> all outputs 0 immediately; after release, a preloaded full FIFO produces a fresh sop burst.
